// File: rtl/cdc_req_fifo.sv
// cdc_req_fifo
// Source-clock-side request FIFO in front of the CDC handshake cell. It absorbs
// producer bursts and presents one word at a time on a req/rdy interface.
// Word order is preserved. A flush discards everything that is queued.
//
// Parameters:
//   DATA_W   payload width in bits
//   DEPTH    number of entries (a power of two, at least 2)
//
// Ports:
//   clk      source-domain clock
//   rst_n    asynchronous active-low reset
//   flush    synchronous discard of all queued entries
//   req_in   producer offers data_in
//   rdy_in   FIFO accepts data_in this cycle
//   data_in  producer payload
//   req_out  FIFO offers data_out (to the CDC cell's req_in)
//   rdy_out  consumer accepts (from the CDC cell's rdy_in)
//   data_out payload at the head of the FIFO
//   count    current occupancy, 0..DEPTH
//   peak     registered high-water mark of count
//            (present only when CDC_FIFO_PEAK_EN is defined)
//
// Build option:
//   CDC_FIFO_PEAK_EN  adds the peak output and its register.
module cdc_req_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_in,
  output logic                     rdy_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     req_out,
  input  logic                     rdy_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   count
`ifdef CDC_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0]   peak
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  // The pointer MSB is a wrap bit: equal low bits mean empty when the wrap
  // bits match and full when they differ.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // Handshakes depend only on local state and flush, so there is no
  // combinational path from req_in to req_out or from rdy_out to rdy_in.
  assign rdy_in  = !full && !flush;
  assign req_out = !empty && !flush;
  assign push    = req_in && rdy_in;
  assign pop     = req_out && rdy_out;

  assign data_out = mem_q[rptr_q[AW-1:0]];
  assign count    = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      // Memory is intentionally left alone; only the pointers are cleared.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q[AW-1:0]] = data_in;
        wptr_d                = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

`ifdef CDC_FIFO_PEAK_EN
  logic [PW-1:0] peak_q, peak_d;

  // count_d is already zero on a flush cycle, but clear explicitly so the
  // intent does not rely on that.
  always_comb begin
    peak_d = peak_q;
    if (flush) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_cdc_req_fifo.sv
// tb_cdc_req_fifo
// Self-checking bench for cdc_req_fifo. A queue-based model tracks the words
// the FIFO should hold; each cycle the outputs are compared with what the
// model says before the clock edge, then the model is advanced.
module tb_cdc_req_fifo;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              req_in;
  logic              rdy_in;
  logic [DATA_W-1:0] data_in;
  logic              req_out;
  logic              rdy_out;
  logic [DATA_W-1:0] data_out;
  logic [CW-1:0]     count;
`ifdef CDC_FIFO_PEAK_EN
  logic [CW-1:0]     peak;
`endif

  cdc_req_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req_in  (req_in),
    .rdy_in  (rdy_in),
    .data_in (data_in),
    .req_out (req_out),
    .rdy_out (rdy_out),
    .data_out(data_out),
    .count   (count)
`ifdef CDC_FIFO_PEAK_EN
    ,
    .peak    (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DATA_W-1:0] model_q[$];
  int unsigned       model_peak = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check the outputs
  // against the model, take the rising edge, then advance the model.
  task automatic cycle(input logic f, input logic ri, input logic ro,
                       input logic [DATA_W-1:0] d);
    int unsigned sz;
    logic        do_push;
    logic        do_pop;
    flush   = f;
    req_in  = ri;
    rdy_out = ro;
    data_in = d;
    #1;
    sz = model_q.size();
    chk("rdy_in",  {63'd0, rdy_in},  {63'd0, (sz < DEPTH) && !f});
    chk("req_out", {63'd0, req_out}, {63'd0, (sz > 0) && !f});
    chk("count",   DATA_W'(count),   DATA_W'(sz));
    if (sz > 0) chk("data_out", data_out, model_q[0]);
`ifdef CDC_FIFO_PEAK_EN
    chk("peak", DATA_W'(peak), DATA_W'(model_peak));
`endif
    @(posedge clk);
    if (f) begin
      model_q.delete();
      model_peak = 0;
    end else begin
      do_push = ri && (sz < DEPTH);
      do_pop  = ro && (sz > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
      if (model_q.size() > model_peak) model_peak = model_q.size();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    req_in  = 1'b0;
    rdy_out = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdy_in",   {63'd0, rdy_in},  64'd1);
    chk("reset_req_out",  {63'd0, req_out}, 64'd0);
    chk("reset_data_out", data_out,         64'd0);
    chk("reset_count",    DATA_W'(count),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word passes through with rdy_out held high.
    cycle(1'b0, 1'b1, 1'b1, 64'hA5);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);

    // Fill to full, offer a fifth word, then drain in order.
    for (int unsigned i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 1'b0, DATA_W'(i));
    for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0);
`ifdef CDC_FIFO_PEAK_EN
    chk("peak_after_fill", DATA_W'(peak), 64'd4);
`endif

    // Steady state at count 2 with concurrent push and pop across wraps.
    cycle(1'b0, 1'b1, 1'b0, 64'h100);
    cycle(1'b0, 1'b1, 1'b0, 64'h101);
    for (int unsigned i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, DATA_W'(64'h200 + i));
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0);

    // Flush at count 3 with req_in still high.
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DATA_W'(64'h300 + i));
    cycle(1'b1, 1'b1, 1'b0, 64'h3FF);
    cycle(1'b0, 1'b1, 1'b0, 64'h777);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);

`ifdef CDC_FIFO_PEAK_EN
    // High-water mark: fill to 3, drain, then flush clears it.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DATA_W'(64'h400 + i));
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0);
    chk("peak_fill3", DATA_W'(peak), 64'd3);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("peak_flushed", DATA_W'(peak), 64'd0);
`endif

    // Randomized traffic with occasional flushes.
    for (int unsigned i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a burst at count 2.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'hDEAD);
    cycle(1'b0, 1'b1, 1'b0, 64'hBEEF);
    req_in  = 1'b1;
    data_in = 64'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdy_in",   {63'd0, rdy_in},  64'd1);
    chk("async_rst_req_out",  {63'd0, req_out}, 64'd0);
    chk("async_rst_data_out", data_out,         64'd0);
    chk("async_rst_count",    DATA_W'(count),   64'd0);
    model_q.delete();
    model_peak = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 64'h3C);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
